// File: rtl/eth_latency_measurer_stats.sv
`default_nettype none
// ============================================================================
// Module      : eth_latency_measurer_stats
// Description : Accumulates ping/pong latency statistics from the latency
//               measurer coordinator and exposes a coherent snapshot through
//               a four-phase snap_req/snap_ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module eth_latency_measurer_stats #(
    parameter int SUM_WIDTH     = 64,
    parameter bit CLEAR_ON_SNAP = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 done,
    input  logic [31:0]          ping_time,
    input  logic [31:0]          pong_time,
    input  logic                 snap_req,
    output logic                 snap_ack,
    output logic [63:0]          samples,
    output logic [63:0]          pings_lost,
    output logic [63:0]          pongs_lost,
    output logic [31:0]          ping_min,
    output logic [31:0]          ping_max,
    output logic [SUM_WIDTH-1:0] ping_sum,
    output logic [31:0]          pong_min,
    output logic [31:0]          pong_max,
    output logic [SUM_WIDTH-1:0] pong_sum
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b01,
        ST_HOLD = 2'b10
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   w_capture;
    logic   r_ack;

    // Live accumulators
    logic [63:0]          r_l_samples, r_l_pings_lost, r_l_pongs_lost;
    logic [31:0]          r_l_ping_min, r_l_ping_max, r_l_pong_min, r_l_pong_max;
    logic [SUM_WIDTH-1:0] r_l_ping_sum, r_l_pong_sum;

    // Live accumulators with this cycle's sample folded in
    logic [63:0]          w_a_samples, w_a_pings_lost, w_a_pongs_lost;
    logic [31:0]          w_a_ping_min, w_a_ping_max, w_a_pong_min, w_a_pong_max;
    logic [SUM_WIDTH-1:0] w_a_ping_sum, w_a_pong_sum;

    // Snapshot registers
    logic [63:0]          r_s_samples, r_s_pings_lost, r_s_pongs_lost;
    logic [31:0]          r_s_ping_min, r_s_ping_max, r_s_pong_min, r_s_pong_max;
    logic [SUM_WIDTH-1:0] r_s_ping_sum, r_s_pong_sum;

    // One extra bit on the adders exposes the carry used for saturation
    logic [SUM_WIDTH:0] w_ping_add, w_pong_add;
    assign w_ping_add = {1'b0, r_l_ping_sum} + {{(SUM_WIDTH-31){1'b0}}, ping_time};
    assign w_pong_add = {1'b0, r_l_pong_sum} + {{(SUM_WIDTH-31){1'b0}}, pong_time};

    // Classify the incoming result and fold it into a copy of the live stats
    always_comb begin
        w_a_samples    = r_l_samples;
        w_a_pings_lost = r_l_pings_lost;
        w_a_pongs_lost = r_l_pongs_lost;
        w_a_ping_min   = r_l_ping_min;
        w_a_ping_max   = r_l_ping_max;
        w_a_ping_sum   = r_l_ping_sum;
        w_a_pong_min   = r_l_pong_min;
        w_a_pong_max   = r_l_pong_max;
        w_a_pong_sum   = r_l_pong_sum;
        if (done) begin
            if (ping_time == 32'hFFFF_FFFF) begin
                if (r_l_pings_lost != {64{1'b1}})
                    w_a_pings_lost = r_l_pings_lost + 64'd1;
            end else if (pong_time == 32'hFFFF_FFFF) begin
                if (r_l_pongs_lost != {64{1'b1}})
                    w_a_pongs_lost = r_l_pongs_lost + 64'd1;
            end else begin
                if (r_l_samples != {64{1'b1}})
                    w_a_samples = r_l_samples + 64'd1;
                if (ping_time < r_l_ping_min) w_a_ping_min = ping_time;
                if (ping_time > r_l_ping_max) w_a_ping_max = ping_time;
                if (pong_time < r_l_pong_min) w_a_pong_min = pong_time;
                if (pong_time > r_l_pong_max) w_a_pong_max = pong_time;
                w_a_ping_sum = w_ping_add[SUM_WIDTH] ? {SUM_WIDTH{1'b1}}
                                                     : w_ping_add[SUM_WIDTH-1:0];
                w_a_pong_sum = w_pong_add[SUM_WIDTH] ? {SUM_WIDTH{1'b1}}
                                                     : w_pong_add[SUM_WIDTH-1:0];
            end
        end
    end

    // Handshake next-state decode; an illegal encoding falls back to idle
    always_comb begin
        w_next_state = r_state;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (snap_req) begin
                    w_capture    = 1'b1;
                    w_next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!snap_req)
                    w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register and registered acknowledge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ack   <= (w_next_state == ST_HOLD);
        end
    end

    // Live accumulators: empty on reset, clear, or capture when restarting per snapshot
    always_ff @(posedge clk) begin
        if (rst || clear || (w_capture && CLEAR_ON_SNAP)) begin
            r_l_samples    <= '0;
            r_l_pings_lost <= '0;
            r_l_pongs_lost <= '0;
            r_l_ping_min   <= 32'hFFFF_FFFF;
            r_l_ping_max   <= '0;
            r_l_ping_sum   <= '0;
            r_l_pong_min   <= 32'hFFFF_FFFF;
            r_l_pong_max   <= '0;
            r_l_pong_sum   <= '0;
        end else begin
            r_l_samples    <= w_a_samples;
            r_l_pings_lost <= w_a_pings_lost;
            r_l_pongs_lost <= w_a_pongs_lost;
            r_l_ping_min   <= w_a_ping_min;
            r_l_ping_max   <= w_a_ping_max;
            r_l_ping_sum   <= w_a_ping_sum;
            r_l_pong_min   <= w_a_pong_min;
            r_l_pong_max   <= w_a_pong_max;
            r_l_pong_sum   <= w_a_pong_sum;
        end
    end

    // Snapshot capture includes a coincident sample and ignores clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_samples    <= '0;
            r_s_pings_lost <= '0;
            r_s_pongs_lost <= '0;
            r_s_ping_min   <= 32'hFFFF_FFFF;
            r_s_ping_max   <= '0;
            r_s_ping_sum   <= '0;
            r_s_pong_min   <= 32'hFFFF_FFFF;
            r_s_pong_max   <= '0;
            r_s_pong_sum   <= '0;
        end else if (w_capture) begin
            r_s_samples    <= w_a_samples;
            r_s_pings_lost <= w_a_pings_lost;
            r_s_pongs_lost <= w_a_pongs_lost;
            r_s_ping_min   <= w_a_ping_min;
            r_s_ping_max   <= w_a_ping_max;
            r_s_ping_sum   <= w_a_ping_sum;
            r_s_pong_min   <= w_a_pong_min;
            r_s_pong_max   <= w_a_pong_max;
            r_s_pong_sum   <= w_a_pong_sum;
        end
    end

    assign snap_ack   = r_ack;
    assign samples    = r_s_samples;
    assign pings_lost = r_s_pings_lost;
    assign pongs_lost = r_s_pongs_lost;
    assign ping_min   = r_s_ping_min;
    assign ping_max   = r_s_ping_max;
    assign ping_sum   = r_s_ping_sum;
    assign pong_min   = r_s_pong_min;
    assign pong_max   = r_s_pong_max;
    assign pong_sum   = r_s_pong_sum;

endmodule
`default_nettype wire

// File: doc/eth_latency_measurer_stats.md
Name: eth_latency_measurer_stats

Overview:
- Sits directly downstream of the latency measurer coordinator and consumes its per-measurement result (done pulse, ping_time, pong_time).
- Accumulates live statistics: valid-sample count, lost counts, and min/max/sum of ping and pong latency.
- Exposes a coherent snapshot of those statistics to the register interface through a four-phase req/ack handshake.
- Software reads all snapshot registers after ack without tearing.

Parameters:
SUM_WIDTH, 64, width of ping_sum/pong_sum accumulators (range 33..64).
CLEAR_ON_SNAP, 1, 1 = live accumulators restart from empty on every snapshot; 0 = snapshots are cumulative.

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high, clock clk
clear  in  1  synchronous clear of live accumulators (snapshot regs untouched)
done  in  1  one-cycle pulse: new measurement result valid
ping_time  in  32  ping latency in cycles; all-ones = ping lost
pong_time  in  32  pong latency in cycles; all-ones = pong lost
snap_req  in  1  level request for snapshot (four-phase)
snap_ack  out  1  snapshot valid/held
samples  out  64  snapshot: count of results with both times valid
pings_lost  out  64  snapshot: results with ping_time all-ones
pongs_lost  out  64  snapshot: results with ping valid, pong_time all-ones
ping_min  out  32  snapshot min ping_time over valid samples
ping_max  out  32  snapshot max ping_time
ping_sum  out  SUM_WIDTH  snapshot sum of ping_time
pong_min  out  32  snapshot min pong_time
pong_max  out  32  snapshot max pong_time
pong_sum  out  SUM_WIDTH  snapshot sum of pong_time

Behaviour:
- Reset values: all snapshot outputs 0 except ping_min/pong_min = 32'hFFFFFFFF; snap_ack = 0; FSM = ST_IDLE.
- Live accumulators reset to the same values ("empty" state: min all-ones, max 0, sums/counts 0).
- Sample classification on done=1, evaluated in this order:
  - ping_time all-ones: pings_lost +1; pong_time ignored.
  - else pong_time all-ones: pongs_lost +1.
  - else valid: samples +1, min/max updated, sums += zero-extended times.
- Sample latency: done at edge N → live accumulators reflect the sample after edge N.
- Arithmetic:
  - Sums saturate at all-ones of SUM_WIDTH and never wrap.
  - 64-bit counters saturate at all-ones.
  - Min/max comparisons are unsigned.
  - A time equal to current min/max leaves it unchanged.
- done while rst=1: ignored.
- Precedence in one cycle:
  - clear=1 with done=1: live set to empty; the sample is dropped.
  - clear=1 does not affect snapshot regs or the FSM.
- FSM ST_IDLE:
  - snap_req=1 at an edge: snapshot regs load accum(live, sample-this-cycle), so a coincident done is included.
  - Same edge: if CLEAR_ON_SNAP=1 or clear=1, live → empty; otherwise live → accum(live, sample).
  - Same edge: snap_ack ← 1 and go to ST_HOLD. Ack is visible the cycle after req is sampled high.
  - If clear=1 coincides with the capture, the snapshot still captures pre-clear values plus the sample.
- FSM ST_HOLD:
  - Snapshot regs frozen; accumulation continues in live.
  - snap_req=0 at an edge: snap_ack ← 0 and go to ST_IDLE.
  - A new snapshot needs snap_req low for ≥1 sampled edge, then high again.
- rst mid-handshake: FSM to ST_IDLE, snap_ack = 0, all regs to reset values.
- Illegal FSM encoding: recover to ST_IDLE with snap_ack = 0.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, then snap_req=1 → snap_ack=1 one cycle later; samples=0, ping_min=FFFFFFFF, ping_max=0, sums=0. Drop req → ack=0 next cycle.
- done ×3 with (ping, pong) = (100,200), (50,300), (75,250); then snapshot → samples=3, ping_min=50, ping_max=100, ping_sum=225, pong_min=200, pong_max=300, pong_sum=750.
- done with (FFFFFFFF,FFFFFFFF), then (10,FFFFFFFF), then snapshot → pings_lost=1, pongs_lost=1, samples=0, mins still FFFFFFFF.
- done (5,6) in the same cycle as the snap_req rising edge, CLEAR_ON_SNAP=1 → snapshot samples=1, ping_sum=5. Second snapshot with no further done → samples=0.
- clear=1 with done=1 (9,9), then snapshot → samples=0. With CLEAR_ON_SNAP=0, two snapshots around done (4,4) → second shows samples=previous+1.
- SUM_WIDTH=33, feed two samples ping=FFFFFFFE and FFFFFFFE, then a third → ping_sum saturates at 1FFFFFFFF. Assert rst during ST_HOLD → snap_ack=0 the next cycle and all outputs at reset values.
